// File: rtl/mul_seq_booth.sv
// mul_seq_booth: iterative Booth multiplier with a start/busy/ready handshake.
// Produces the exact 2*WIDTH-bit product of two WIDTH-bit operands. Each
// operation is signed or unsigned, selected by `sign` together with `start`.
// Optional macro MUL_SEQ_BOOTH_RADIX4_EN selects radix-4 (modified) Booth
// recoding, which retires two multiplier bits per cycle. When the macro is
// undefined the design uses radix-2 recoding and retires one bit per cycle.
module mul_seq_booth #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] z
);

`ifdef MUL_SEQ_BOOTH_RADIX4_EN
  localparam int SH = 2;          // multiplier bits retired per iteration
  localparam int EW = WIDTH + 2;  // extended operand width (even, so EW/2 steps)
`else
  localparam int SH = 1;
  localparam int EW = WIDTH + 1;
`endif
  localparam int N  = EW / SH;          // iteration count
  localparam int AW = EW + 2;           // accumulator has headroom for the +/-2A step
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   ma;    // extended multiplicand
  logic [AW-1:0]   acc;   // upper half of the running product
  logic [EW-1:0]   mq;    // multiplier, shifted out as product bits shift in
  logic            qm1;   // Booth look-behind bit

  logic [AW-1:0]   pp;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_n;
  logic [EW-1:0]   mq_n;
  logic            qm1_n;

  // One Booth step: select the partial product, add it, then shift
  // {acc, mq, qm1} arithmetically right by SH bits.
  always_comb begin
    pp = '0;
`ifdef MUL_SEQ_BOOTH_RADIX4_EN
    case ({mq[1:0], qm1})
      3'b001, 3'b010: pp = ma;
      3'b011:         pp = ma << 1;
      3'b100:         pp = -(ma << 1);
      3'b101, 3'b110: pp = -ma;
      default:        pp = '0;
    endcase
`else
    case ({mq[0], qm1})
      2'b01:   pp = ma;
      2'b10:   pp = -ma;
      default: pp = '0;
    endcase
`endif
    sum   = acc + pp;
    acc_n = {{SH{sum[AW-1]}}, sum[AW-1:SH]};
    mq_n  = {sum[SH-1:0], mq[EW-1:SH]};
    qm1_n = mq[SH-1];
  end

  // Control FSM and datapath registers. Operands are extended once at
  // acceptance so that unsigned values become non-negative signed values
  // and one signed Booth datapath serves both modes.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      z     <= '0;
      ma    <= '0;
      acc   <= '0;
      mq    <= '0;
      qm1   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ma    <= {{(AW-WIDTH){sign & a[WIDTH-1]}}, a};
            mq    <= {{(EW-WIDTH){sign & b[WIDTH-1]}}, b};
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_n;
          mq  <= mq_n;
          qm1 <= qm1_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            // The low 2*WIDTH bits of {acc, mq} are the exact product.
            z     <= {acc_n[2*WIDTH-EW-1:0], mq_n};
            ready <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_booth.sv
// Directed testbench for mul_seq_booth at WIDTH=8, plus a short random
// sweep against a reference product computed in the bench.
module tb_mul_seq_booth;

`ifdef MUL_SEQ_BOOTH_RADIX4_EN
  localparam int N = 5;
`else
  localparam int N = 9;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic        sign;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        ready;
  logic [15:0] z;

  int total = 0;
  int bad   = 0;

  mul_seq_booth #(.WIDTH(8)) dut (
    .clk(clk), .clrn(clrn), .start(start), .sign(sign),
    .a(a), .b(b), .busy(busy), .ready(ready), .z(z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs during CALC, check latency and result.
  task automatic mul_op(input string tag, input logic s, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] want);
    int cyc;
    sign = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    sign = ~s; a = ~x; b = y ^ 8'h5a;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!ready && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, N);
    chk({tag, "_z"}, {16'd0, z}, {16'd0, want});
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    int cyc;
    int rdy_cnt;
    int early_drop;
    logic [15:0] zcap;
    logic [7:0] rx, ry;
    logic rs;
    logic signed [15:0] sp;
    logic [15:0] rp;

    clrn = 1'b0; start = 1'b1; sign = 1'b0; a = 8'h12; b = 8'h34;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_z", {16'd0, z}, 32'd0);
    start = 1'b0;
    clrn = 1'b1;
    tick();
    chk("rst_rel_busy", {31'd0, busy}, 32'd0);

    // Signed vectors
    mul_op("s_ffff", 1'b1, 8'hff, 8'hff, 16'h0001);
    mul_op("s_8181", 1'b1, 8'h81, 8'h81, 16'h3f01);
    mul_op("s_7e81", 1'b1, 8'h7e, 8'h81, 16'hc17e);
    mul_op("s_807f", 1'b1, 8'h80, 8'h7f, 16'hc080);
    mul_op("s_8080", 1'b1, 8'h80, 8'h80, 16'h4000);
    // Unsigned vectors
    mul_op("u_ffff", 1'b0, 8'hff, 8'hff, 16'hfe01);
    mul_op("u_8080", 1'b0, 8'h80, 8'h80, 16'h4000);
    mul_op("u_007f", 1'b0, 8'h00, 8'h7f, 16'h0000);
    mul_op("u_ff01", 1'b0, 8'hff, 8'h01, 16'h00ff);

    // Start while busy is ignored
    sign = 1'b0; a = 8'h02; b = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'h7f; b = 8'h7f; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bz_busy", {31'd0, busy}, 32'd1);
    rdy_cnt = 0; early_drop = 0; zcap = 16'hdead;
    for (int i = 0; i < N + 4; i++) begin
      if (!busy && rdy_cnt == 0 && !ready) early_drop++;
      tick();
      if (ready) begin
        rdy_cnt++;
        zcap = z;
      end
    end
    chk("bz_pulses", rdy_cnt, 1);
    chk("bz_z", {16'd0, zcap}, 32'h0006);
    chk("bz_busy_held", early_drop, 0);

    // Back-to-back
    sign = 1'b1; a = 8'h03; b = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("b2b_lat1", cyc, N);
    chk("b2b_z1", {16'd0, z}, 32'h0009);
    sign = 1'b1; a = 8'hfe; b = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_pulse", {31'd0, ready}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!ready && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("b2b_gap", cyc, N + 1);
    chk("b2b_z2", {16'd0, z}, 32'h0000fff6);
    tick();

    // Reset mid-CALC
    sign = 1'b1; a = 8'h7f; b = 8'h7f; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_ready", {31'd0, ready}, 32'd0);
    chk("rmid_z", {16'd0, z}, 32'd0);
    rdy_cnt = 0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      if (ready) rdy_cnt++;
    end
    chk("rmid_noready", rdy_cnt, 0);
    chk("rmid_zhold", {16'd0, z}, 32'd0);
    mul_op("rmid_after", 1'b1, 8'h7f, 8'h7f, 16'h3f01);

    // Short random sweep against a bench-side reference product
    for (int i = 0; i < 200; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rs = 1'($urandom);
      sp = $signed(rx) * $signed(ry);
      rp = {8'd0, rx} * {8'd0, ry};
      mul_op("rnd", rs, rx, ry, rs ? sp : rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
